// File: rtl/cond_flag_unit.sv
// -----------------------------------------------------------------------------
// cond_flag_unit
//   Consumer end of the ALU condition-code path. Holds the program status
//   flags {C,N,V,Z}, counts flag-writing instructions that have issued from ID
//   but not yet committed in EX, and answers condition-field queries from
//   branch / conditional-execute logic. A query whose flags are still in
//   flight is parked (stall=1) until the last pending flag write commits.
//
// Handshake (request side):
//   cond_req/cond_code is held stable by the requester until accepted;
//   accept = cond_req & cond_ready. cond_ready is high only while idle.
//   The answer is a single-cycle cond_valid pulse with cond_true alongside;
//   there is no back-pressure on the answer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_c/n/v/z                live ALU flags from EX
//   flag_we_ex                 EX instruction commits alu_* into PSR this edge
//   flag_we_id                 ID instruction with S bit issues (becomes pending)
//   flush                      clears pending count, drops a parked request
//   cond_req, cond_code        request valid and 4-bit condition field
//   cond_ready                 request can be accepted
//   cond_valid, cond_true      one-cycle answer pulse and outcome
//   stall                      hold ID: request parked on pending flags
//   psr_c/n/v/z                current PSR flags
//   pend_err                   sticky: issue at full count or commit at zero
//   dbg_state_o                FSM state (0 IDLE, 1 WAIT, 2 RESP)
//   dbg_pend_cnt_o             pending flag-write count
// -----------------------------------------------------------------------------
module cond_flag_unit #(
    parameter int MAX_PEND = 3,
    parameter bit FORWARD  = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alu_c,
    input  logic                            alu_n,
    input  logic                            alu_v,
    input  logic                            alu_z,
    input  logic                            flag_we_ex,
    input  logic                            flag_we_id,
    input  logic                            flush,
    input  logic                            cond_req,
    input  logic [3:0]                      cond_code,
    output logic                            cond_ready,
    output logic                            cond_valid,
    output logic                            cond_true,
    output logic                            stall,
    output logic                            psr_c,
    output logic                            psr_n,
    output logic                            psr_v,
    output logic                            psr_z,
    output logic                            pend_err,
    output logic [1:0]                      dbg_state_o,
    output logic [$clog2(MAX_PEND+1)-1:0]   dbg_pend_cnt_o
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);
    localparam logic [CW-1:0] PEND_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Flag vectors are always ordered {C,N,V,Z}.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic c, n, v, z;
        logic r;
        {c, n, v, z} = f;
        case (code)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c && !z;
            4'h9:    r = !c || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;   // NV: reserved, never true
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- PSR
    logic [3:0] psr_q, psr_d;
    logic [3:0] alu_flags;

    assign alu_flags = {alu_c, alu_n, alu_v, alu_z};
    assign psr_d     = flag_we_ex ? alu_flags : psr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q <= 4'b0000;
        end else begin
            psr_q <= psr_d;
        end
    end

    // ------------------------------------------------------ pending count
    logic [CW-1:0] pend_q, pend_d;
    logic          pend_err_q, pend_err_d;

    always_comb begin
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        // A simultaneous issue and commit cancel out.
        if (flag_we_id && !flag_we_ex) begin
            if (pend_q == PEND_MAX) begin
                pend_err_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (flag_we_ex && !flag_we_id) begin
            if (pend_q == '0) begin
                pend_err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_ONE;
            end
        end
        // Flush wins over any same-edge count change; the error stays sticky.
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_err_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
        end
    end

    // -------------------------------------------------------- request FSM
    state_t     state_q;
    logic [3:0] code_q;
    logic       defer_q;        // final commit seen, answer from PSR next cycle
    logic       cond_ready_q;
    logic       cond_valid_q;
    logic       cond_true_q;
    logic       stall_q;
    logic       accept;
    logic       last_commit;

    assign accept      = cond_req && cond_ready_q;
    assign last_commit = (pend_q == PEND_ONE) && flag_we_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            code_q       <= 4'h0;
            defer_q      <= 1'b0;
            cond_ready_q <= 1'b1;
            cond_valid_q <= 1'b0;
            cond_true_q  <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            cond_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        code_q  <= cond_code;
                        defer_q <= 1'b0;
                        if (pend_q == '0) begin
                            // Flags are final; include any commit on this same edge.
                            state_q      <= S_RESP;
                            cond_true_q  <= eval_cond(cond_code, psr_d);
                            cond_valid_q <= 1'b1;
                            cond_ready_q <= 1'b0;
                        end else if (!flush) begin
                            state_q      <= S_WAIT;
                            cond_ready_q <= 1'b0;
                            stall_q      <= 1'b1;
                        end
                        // Accept with flush while flags are pending: dropped.
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q      <= S_IDLE;
                        cond_ready_q <= 1'b1;
                        stall_q      <= 1'b0;
                        defer_q      <= 1'b0;
                    end else if (defer_q) begin
                        state_q      <= S_RESP;
                        cond_true_q  <= eval_cond(code_q, psr_q);
                        cond_valid_q <= 1'b1;
                        stall_q      <= 1'b0;
                        defer_q      <= 1'b0;
                    end else if (last_commit) begin
                        if (FORWARD) begin
                            state_q      <= S_RESP;
                            cond_true_q  <= eval_cond(code_q, alu_flags);
                            cond_valid_q <= 1'b1;
                            stall_q      <= 1'b0;
                        end else begin
                            defer_q <= 1'b1;
                        end
                    end else if (pend_q == '0) begin
                        // Nothing left in flight (count lost to misuse): answer
                        // from PSR rather than waiting forever.
                        state_q      <= S_RESP;
                        cond_true_q  <= eval_cond(code_q, psr_d);
                        cond_valid_q <= 1'b1;
                        stall_q      <= 1'b0;
                    end
                end
                S_RESP: begin
                    // Flush here is ignored: the answer already went out.
                    state_q      <= S_IDLE;
                    cond_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    cond_ready_q <= 1'b1;
                    stall_q      <= 1'b0;
                    defer_q      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign cond_ready     = cond_ready_q;
    assign cond_valid     = cond_valid_q;
    assign cond_true      = cond_true_q;
    assign stall          = stall_q;
    assign {psr_c, psr_n, psr_v, psr_z} = psr_q;
    assign pend_err       = pend_err_q;
    assign dbg_state_o    = state_q;
    assign dbg_pend_cnt_o = pend_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

    localparam int MAX_PEND = 3;

    logic       clk;
    logic       rst_n;
    logic       alu_c, alu_n, alu_v, alu_z;
    logic       flag_we_ex, flag_we_id, flush, cond_req;
    logic [3:0] cond_code;

    logic       cond_ready, cond_valid, cond_true, stall;
    logic       psr_c, psr_n, psr_v, psr_z, pend_err;
    logic [1:0] dbg_state;
    logic [1:0] dbg_pend;

    logic       f0_ready, f0_valid, f0_true, f0_stall;
    logic       f0_psr_c, f0_psr_n, f0_psr_v, f0_psr_z, f0_err;
    logic [1:0] f0_state;
    logic [1:0] f0_pend;

    cond_flag_unit #(.MAX_PEND(MAX_PEND), .FORWARD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
        .flag_we_ex(flag_we_ex), .flag_we_id(flag_we_id), .flush(flush),
        .cond_req(cond_req), .cond_code(cond_code),
        .cond_ready(cond_ready), .cond_valid(cond_valid), .cond_true(cond_true),
        .stall(stall), .psr_c(psr_c), .psr_n(psr_n), .psr_v(psr_v), .psr_z(psr_z),
        .pend_err(pend_err), .dbg_state_o(dbg_state), .dbg_pend_cnt_o(dbg_pend)
    );

    cond_flag_unit #(.MAX_PEND(MAX_PEND), .FORWARD(1'b0)) dut_f0 (
        .clk(clk), .rst_n(rst_n),
        .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
        .flag_we_ex(flag_we_ex), .flag_we_id(flag_we_id), .flush(flush),
        .cond_req(cond_req), .cond_code(cond_code),
        .cond_ready(f0_ready), .cond_valid(f0_valid), .cond_true(f0_true),
        .stall(f0_stall), .psr_c(f0_psr_c), .psr_n(f0_psr_n), .psr_v(f0_psr_v), .psr_z(f0_psr_z),
        .pend_err(f0_err), .dbg_state_o(f0_state), .dbg_pend_cnt_o(f0_pend)
    );

    // ------------------------------------------------ clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------ scoreboard
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: flags {C,N,V,Z}, an outstanding-commit count, and a
    // parked request that needs a known number of further commits.
    logic [3:0] m_psr;
    int         m_pend;
    logic       m_err;
    logic       m_busy;
    int         m_resp;      // cycle of the answer pulse, -1 while still parked
    int         m_left;      // commits still needed by the parked request
    logic [3:0] m_code;
    logic       req_hold;
    logic [0:0] exp_q[$];
    int         exp_cyc[$];

    // Predicates come in true/inverted pairs selected by code[3:1].
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic c, n, v, z;
        logic [7:0] base;
        {c, n, v, z} = f;
        base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
        return base[code[3:1]] ^ code[0];
    endfunction

    task automatic model_reset();
        m_psr  = 4'b0000;
        m_pend = 0;
        m_err  = 1'b0;
        m_busy = 1'b0;
        m_resp = -1;
        m_left = 0;
        m_code = 4'h0;
        req_hold = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
    endtask

    task automatic model_check();
        logic exp_v;
        exp_v = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
        check("valid", 32'(cond_valid), 32'(exp_v));
        if (exp_v) begin
            check("true", 32'(cond_true), 32'(exp_q.pop_front()));
            void'(exp_cyc.pop_front());
        end
        check("ready", 32'(cond_ready), 32'(!m_busy));
        check("stall", 32'(stall), 32'(m_busy && (m_resp != cyc)));
        check("psr", 32'({psr_c, psr_n, psr_v, psr_z}), 32'(m_psr));
        check("pend", 32'(dbg_pend), 32'(m_pend));
        check("err", 32'(pend_err), 32'(m_err));
    endtask

    task automatic model_step();
        int p;
        logic [3:0] alu;
        logic [3:0] psr_next;
        if (!rst_n) return;
        p        = m_pend;
        alu      = {alu_c, alu_n, alu_v, alu_z};
        psr_next = flag_we_ex ? alu : m_psr;
        if (!m_busy) begin
            if (cond_req) begin
                req_hold = 1'b0;
                if (p == 0) begin
                    m_busy = 1'b1;
                    m_resp = cyc + 1;
                    exp_cyc.push_back(cyc + 1);
                    exp_q.push_back(ref_cond(cond_code, psr_next));
                end else if (!flush) begin
                    m_busy = 1'b1;
                    m_resp = -1;
                    m_left = p;
                    m_code = cond_code;
                end
            end
        end else if (m_resp == cyc) begin
            m_busy = 1'b0;
        end else if (m_resp < 0) begin
            if (flush) begin
                m_busy = 1'b0;
            end else if (flag_we_ex) begin
                m_left--;
                if (m_left == 0) begin
                    m_resp = cyc + 1;
                    exp_cyc.push_back(cyc + 1);
                    exp_q.push_back(ref_cond(m_code, alu));
                end
            end
        end
        if (flag_we_id && !flag_we_ex) begin
            if (p == MAX_PEND) m_err = 1'b1; else m_pend = p + 1;
        end else if (flag_we_ex && !flag_we_id) begin
            if (p == 0) m_err = 1'b1; else m_pend = p - 1;
        end
        if (flush) m_pend = 0;
        m_psr = psr_next;
    endtask

    // One clock: check at the falling edge, advance model, land just after
    // the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic idle_inputs();
        {alu_c, alu_n, alu_v, alu_z} = 4'b0000;
        flag_we_ex = 1'b0;
        flag_we_id = 1'b0;
        flush      = 1'b0;
        cond_req   = 1'b0;
        cond_code  = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic gen_inputs();
        logic hazard;
        {alu_c, alu_n, alu_v, alu_z} = 4'($urandom_range(0, 15));
        if (!req_hold && $urandom_range(0, 3) == 0) begin
            req_hold  = 1'b1;
            cond_code = 4'($urandom_range(0, 15));
        end
        cond_req = req_hold;
        hazard   = cond_req && !m_busy && (m_pend != 0);
        if (!m_busy && !cond_req)
            flag_we_id = ($urandom_range(0, (m_pend == MAX_PEND) ? 19 : 3) == 0);
        else
            flag_we_id = 1'b0;
        if (hazard)
            flag_we_ex = 1'b0;
        else
            flag_we_ex = ($urandom_range(0, (m_pend > 0) ? 1 : 19) == 0);
        flush = !hazard && ($urandom_range(0, 39) == 0);
    endtask

    // ------------------------------------------------------------ tests
    logic [15:0] sweep_exp;

    initial begin
        sweep_exp = 16'b0101_0110_0101_1010;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        cycle();
        check("rst_ready", 32'(cond_ready), 32'(1));
        check("rst_psr", 32'({psr_c, psr_n, psr_v, psr_z}), 32'(0));
        rst_n = 1'b1;

        // Underflow: commit with nothing pending still writes PSR.
        do_reset();
        flag_we_ex = 1'b1;
        {alu_c, alu_n, alu_v, alu_z} = 4'b1011;
        cycle();
        idle_inputs();
        check("uf_psr", 32'({psr_c, psr_n, psr_v, psr_z}), 32'(4'b1011));
        check("uf_pend", 32'(dbg_pend), 32'(0));
        check("uf_err", 32'(pend_err), 32'(1));
        cycle();

        // Counter saturation and simultaneous issue+commit.
        do_reset();
        flag_we_id = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("cnt_full", 32'(dbg_pend), 32'(3));
        check("cnt_noerr", 32'(pend_err), 32'(0));
        cycle();
        check("cnt_sat", 32'(dbg_pend), 32'(3));
        check("cnt_oferr", 32'(pend_err), 32'(1));
        flag_we_ex = 1'b1;
        cycle();
        check("cnt_both", 32'(dbg_pend), 32'(3));
        flag_we_id = 1'b0;
        cycle();
        check("cnt_dec", 32'(dbg_pend), 32'(2));
        idle_inputs();
        cycle();

        // Table sweep with PSR = N=1 V=1 C=0 Z=0; ALU inputs differ afterwards.
        do_reset();
        flag_we_id = 1'b1;
        cycle();
        flag_we_id = 1'b0;
        flag_we_ex = 1'b1;
        {alu_c, alu_n, alu_v, alu_z} = 4'b0110;
        cycle();
        flag_we_ex = 1'b0;
        {alu_c, alu_n, alu_v, alu_z} = 4'b1001;
        check("sw_psr", 32'({psr_c, psr_n, psr_v, psr_z}), 32'(4'b0110));
        for (int k = 0; k < 16; k++) begin
            cond_req  = 1'b1;
            cond_code = 4'(k);
            cycle();
            cond_req = 1'b0;
            check($sformatf("sw_valid_%0d", k), 32'(cond_valid), 32'(1));
            check($sformatf("sw_true_%0d", k), 32'(cond_true), 32'(sweep_exp[k]));
            cycle();
        end
        idle_inputs();

        // Hazard: both forwarding options.
        do_reset();
        flag_we_id = 1'b1;
        cycle();
        flag_we_id = 1'b0;
        cond_req   = 1'b1;
        cond_code  = 4'h0;
        cycle();
        cond_req = 1'b0;
        check("hz_stall", 32'(stall), 32'(1));
        check("hz_stall_f0", 32'(f0_stall), 32'(1));
        flag_we_ex = 1'b1;
        {alu_c, alu_n, alu_v, alu_z} = 4'b0001;
        cycle();
        idle_inputs();
        check("hz_valid", 32'(cond_valid), 32'(1));
        check("hz_true", 32'(cond_true), 32'(1));
        check("hz_f0_early", 32'(f0_valid), 32'(0));
        check("hz_f0_stall", 32'(f0_stall), 32'(1));
        cycle();
        check("hz_f0_valid", 32'(f0_valid), 32'(1));
        check("hz_f0_true", 32'(f0_true), 32'(1));
        check("hz_f0_psr", 32'({f0_psr_c, f0_psr_n, f0_psr_v, f0_psr_z}), 32'(4'b0001));
        cycle();
        check("hz_f0_ready", 32'(f0_ready), 32'(1));
        check("hz_f0_pend", 32'(f0_pend), 32'(0));
        check("hz_f0_err", 32'(f0_err), 32'(0));
        check("hz_f0_state", 32'(f0_state), 32'(0));

        // Flush while parked with two pending writes.
        do_reset();
        flag_we_id = 1'b1;
        cycle();
        cycle();
        flag_we_id = 1'b0;
        cond_req   = 1'b1;
        cond_code  = 4'hE;
        cycle();
        cond_req = 1'b0;
        check("fl_stall", 32'(stall), 32'(1));
        check("fl_pend", 32'(dbg_pend), 32'(2));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_stall_clr", 32'(stall), 32'(0));
        check("fl_ready", 32'(cond_ready), 32'(1));
        check("fl_pend_clr", 32'(dbg_pend), 32'(0));
        for (int i = 0; i < 3; i++) begin
            check("fl_novalid", 32'(cond_valid), 32'(0));
            cycle();
        end

        // Reset asserted while parked.
        flag_we_id = 1'b1;
        cycle();
        flag_we_id = 1'b0;
        cond_req   = 1'b1;
        cond_code  = 4'h1;
        cycle();
        cond_req = 1'b0;
        check("rw_stall", 32'(stall), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_ready", 32'(cond_ready), 32'(1));
        check("rw_valid", 32'(cond_valid), 32'(0));
        check("rw_true", 32'(cond_true), 32'(0));
        check("rw_stall0", 32'(stall), 32'(0));
        check("rw_psr", 32'({psr_c, psr_n, psr_v, psr_z}), 32'(0));
        check("rw_err", 32'(pend_err), 32'(0));
        check("rw_pend", 32'(dbg_pend), 32'(0));
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        flag_we_ex = 1'b1;
        {alu_c, alu_n, alu_v, alu_z} = 4'b1111;
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("rw_novalid", 32'(cond_valid), 32'(0));
            cycle();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            gen_inputs();
            cycle();
        end
        idle_inputs();
        for (int n = 0; n < 4; n++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
